// File: rtl/join_vector_pkg.sv
// Shared vector-unit definitions: gather/scatter FSM states and default
// vector geometry, common to the join (gather) and fork (scatter) sides.
package join_vector_pkg;

   // Default element width, elements per vector register, lanes per chunk
   localparam int unsigned DEF_N = 32;
   localparam int unsigned DEF_V = 20;
   localparam int unsigned DEF_L = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DONE    = 2'd2
   } state_t;

endpackage : join_vector_pkg

// File: rtl/join_vector.sv
// Gathers V/L chunks of L lane results into one V-element vector register
// image, then pulses done_o for one cycle with the assembled vector.
module join_vector
   import join_vector_pkg::*;
#(
   parameter int unsigned N = DEF_N,
   parameter int unsigned V = DEF_V,
   parameter int unsigned L = DEF_L
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      start_i,
   input  logic                      valid_i,
   input  logic [L-1:0][N-1:0]       Vec_R_i,
   output logic                      ready_o,
   output logic                      busy_o,
   output logic                      done_o,
   output logic [V-1:0][N-1:0]       WD_VEC_o
);

   localparam int unsigned C  = V / L;
   localparam int unsigned KW = (C > 1) ? $clog2(C) : 1;
   localparam int unsigned IW = (V > 1) ? $clog2(V) : 1;
   localparam logic [KW-1:0] LAST = KW'(C - 1);

   // Geometry guard: a vector must split into whole chunks
   if ((V % L) != 0 || L == 0) begin : g_geom_check
      $error("join_vector: V (%0d) must be a non-zero multiple of L (%0d)", V, L);
   end

   state_t          state_q, state_d;
   logic [KW-1:0]   cnt_q;
   logic            clr;
   logic            acc;
   logic [IW-1:0]   base;

   assign base = IW'(32'(cnt_q) * L);

   // State register
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Next-state decode plus clear/accept strobes for the datapath
   always_comb begin
      state_d = state_q;
      clr     = 1'b0;
      acc     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = COLLECT;
               clr     = 1'b1;
            end
         end
         COLLECT: begin
            if (valid_i) begin
               acc = 1'b1;
               if (cnt_q == LAST) state_d = DONE;
            end
         end
         DONE: begin
            if (start_i) begin
               state_d = COLLECT;
               clr     = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Chunk counter: cleared on start, wraps after the last chunk
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)               cnt_q <= '0;
      else if (clr)           cnt_q <= '0;
      else if (acc)           cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + KW'(1);
   end

   // Result vector: cleared on start, chunk k lands at elements k*L .. k*L+L-1
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)               WD_VEC_o <= '0;
      else if (clr)           WD_VEC_o <= '0;
      else if (acc)           WD_VEC_o[base +: L] <= Vec_R_i;
   end

   // Status outputs decode straight from the state register
   always_comb begin
      ready_o = (state_q == COLLECT);
      busy_o  = (state_q == COLLECT);
      done_o  = (state_q == DONE);
   end

endmodule : join_vector
